boron_job_arbiter: RTL

//  Shares one BORON encrypt/decrypt core between N_REQ requesters.

---
 rtl/boron_job_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/boron_job_arbiter.sv
// Round-robin arbiter sharing one BORON encrypt/decrypt core between N_REQ requesters.
// One job in flight: grant, start pulse, wait for done (or abort on timeout), return response.
module boron_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_ready,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_mode,
  input  logic [64*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [63:0]           core_text,
  output logic                  core_enc,
  output logic                  core_dec,
  output logic                  core_rst,
  input  logic                  core_done,
  input  logic [63:0]           core_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           jobs_done
);

  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_ABORT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   text_q, text_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         jobs_q, jobs_d;

  logic                found;
  logic [ID_W-1:0]     win;
  logic                grant;

  // First pending requester at or after rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  assign grant     = (state_q == S_IDLE) && !reset && key_ready && found;
  assign req_ready = grant ? (ONE << win) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    mode_d   = mode_q;
    text_d   = text_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    jobs_d   = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          gid_d    = win;
          mode_d   = req_mode[win];
          text_d   = req_data[int'(win)*DATA_W +: DATA_W];
          rr_ptr_d = ID_W'((int'(win) + 1) % N_REQ);
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the last allowed cycle still counts as success.
        if (core_done) begin
          rdata_d = core_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (!err_q && (jobs_q != 16'hFFFF)) jobs_d = jobs_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      mode_q   <= 1'b0;
      text_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      mode_q   <= mode_d;
      text_q   <= text_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      jobs_q   <= jobs_d;
    end
  end

  assign core_text = text_q;
  assign core_enc  = (state_q == S_START) && !mode_q;
  assign core_dec  = (state_q == S_START) && mode_q;
  assign core_rst  = (state_q == S_ABORT);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = gid_q;
  assign rsp_data  = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign jobs_done = jobs_q;

endmodule
